// File: rtl/bus_arbiter_4to1.sv
// bus_arbiter_4to1: four-requester round-robin bus arbiter with a registered
// one-hot grant, a mandatory one-cycle dead gap between owners and a 4:1 data
// mux driven by the registered owner index.
// Optional feature: define ARB_HOLD_LIMIT_EN to compile in a per-grant hold
// counter that forces release after MAX_HOLD owned cycles and pulses timeout.
module bus_arbiter_4to1 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [3:0]  req,
  input  logic        last,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic [31:0] inC,
  input  logic [31:0] inD,
  output logic [3:0]  gnt,
  output logic [1:0]  sel,
  output logic        busy,
  output logic [31:0] bus_data,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;

  logic        win_valid;
  logic [1:0]  win_idx;
  logic        owner_req;
  logic        hold_hit;

`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0]  hold_cnt_q, hold_cnt_d;
`else
  // The hold limit is compiled out; MAX_HOLD is kept only for a uniform
  // parameter interface across both builds.
  logic [7:0]  unused_max_hold;
  assign unused_max_hold = 8'(MAX_HOLD);
`endif

  // Round-robin pick: first set request bit scanning from rr_ptr upward.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    win_valid = 1'b0;
    win_idx   = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[rr_ptr_q + 2'(k)]) begin
        win_valid = 1'b1;
        win_idx   = rr_ptr_q + 2'(k);
      end
    end
  end

  assign owner_req = req[sel_q];

`ifdef ARB_HOLD_LIMIT_EN
  assign hold_hit = (hold_cnt_q == 8'(MAX_HOLD));
`else
  assign hold_hit = 1'b0;
`endif

  // Next-state and registered-output logic for the IDLE/OWN/GAP machine.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    rr_ptr_d  = rr_ptr_q;
`ifdef ARB_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    unique case (state_q)
      S_IDLE, S_GAP: begin
        if (win_valid) begin
          state_d = S_OWN;
          gnt_d   = 4'b0001 << win_idx;
          sel_d   = win_idx;
          busy_d  = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_d = 8'd1;
`endif
        end else begin
          state_d = S_IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_d = 8'd0;
`endif
        end
      end
      S_OWN: begin
        if (last || !owner_req || hold_hit) begin
          state_d   = S_GAP;
          gnt_d     = 4'b0000;
          busy_d    = 1'b0;
          rr_ptr_d  = sel_q + 2'd1;
          // Only a release caused purely by the hold limit is a timeout.
          timeout_d = hold_hit && !last && owner_req;
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_d = 8'd0;
`endif
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_d = hold_cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any grant immediately.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'b00;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      rr_ptr_q  <= 2'b00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  // Hold counter: counts owned cycles of the current grant.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hold_cnt_q <= 8'd0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  // Data mux: selected word while an owner holds the bus, zero otherwise.
  always_comb begin
    bus_data = 32'h0000_0000;
    if (busy_q) begin
      unique case (sel_q)
        2'd0: bus_data = inA;
        2'd1: bus_data = inB;
        2'd2: bus_data = inC;
        2'd3: bus_data = inD;
        default: bus_data = 32'h0000_0000;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_4to1.sv
// tb_bus_arbiter_4to1: directed self-checking bench for bus_arbiter_4to1.
// The hold-limit section follows ARB_HOLD_LIMIT_EN as the design does.
module tb_bus_arbiter_4to1;

  logic        Clk;
  logic        Rst_n;
  logic [3:0]  req;
  logic        last;
  logic [31:0] inA, inB, inC, inD;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        busy;
  logic [31:0] bus_data;
  logic        timeout;

  int tests_run    = 0;
  int tests_failed = 0;

  bus_arbiter_4to1 #(.MAX_HOLD(4)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .req      (req),
    .last     (last),
    .inA      (inA),
    .inB      (inB),
    .inC      (inC),
    .inD      (inD),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .bus_data (bus_data),
    .timeout  (timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and samples sit 1 time unit after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    last  = 1'b0;
    Rst_n = 1'b0;
    step();
    step();
    Rst_n = 1'b1;
  endtask

  task automatic check_owner(input string tag, input int idx, input logic [31:0] data);
    check({tag, "_gnt"},  32'(gnt),      32'(4'b0001 << idx));
    check({tag, "_sel"},  32'(sel),      32'(idx));
    check({tag, "_busy"}, 32'(busy),     32'd1);
    check({tag, "_data"}, bus_data,      data);
  endtask

  task automatic check_gap(input string tag, input logic exp_to);
    check({tag, "_gnt"},     32'(gnt),     32'd0);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_data"},    bus_data,     32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  logic [31:0] words [4];

  initial begin
    inA = 32'h1111_1111;
    inB = 32'h2222_2222;
    inC = 32'h3333_3333;
    inD = 32'h4444_4444;
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333;
    words[3] = 32'h4444_4444;

    // Reset state.
    do_reset();
    check("rst_gnt",     32'(gnt),     32'd0);
    check("rst_sel",     32'(sel),     32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_data",    bus_data,     32'd0);

    // last while idle has no effect.
    last = 1'b1;
    step();
    check("idle_last_busy", 32'(busy), 32'd0);
    last = 1'b0;

    // req 0101: owner 0, last pulse, gap, owner 2.
    req = 4'b0101;
    step();
    check_owner("basic_o0", 0, words[0]);
    last = 1'b1;
    step();
    last = 1'b0;
    check_gap("basic_gap", 1'b0);
    step();
    check_owner("basic_o2", 2, words[2]);

    // Full contention with last on the third owned cycle: order 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    step();
    for (int n = 0; n < 5; n++) begin
      check_owner("rr_own", n % 4, words[n % 4]);
      step();
      check("rr_hold_gnt", 32'(gnt), 32'(4'b0001 << (n % 4)));
      step();
      check("rr_hold2_busy", 32'(busy), 32'd1);
      last = 1'b1;
      step();
      last = 1'b0;
      check_gap("rr_gap", 1'b0);
      step();
    end

    // Owner 1 data path, release by request drop; sel holds outside OWN.
    do_reset();
    inB = 32'hDEAD_BEEF;
    req = 4'b0010;
    step();
    check_owner("data_o1", 1, 32'hDEAD_BEEF);
    req = 4'b0000;
    step();
    check_gap("data_gap", 1'b0);
    check("data_gap_sel", 32'(sel), 32'd1);
    step();
    check("idle_sel_hold", 32'(sel), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    inB = 32'h2222_2222;

    // last and owner request drop together: single normal release.
    req = 4'b0001;
    step();
    check_owner("both_o0", 0, words[0]);
    req = 4'b0000;
    last = 1'b1;
    step();
    last = 1'b0;
    check_gap("both_gap", 1'b0);

    // Asynchronous reset mid-OWN with owner 2, then rr_ptr back to 0.
    do_reset();
    req = 4'b0100;
    step();
    check_owner("arst_o2", 2, words[2]);
    #1 Rst_n = 1'b0;
    #1;
    check("arst_gnt",     32'(gnt),     32'd0);
    check("arst_busy",    32'(busy),    32'd0);
    check("arst_sel",     32'(sel),     32'd0);
    check("arst_timeout", 32'(timeout), 32'd0);
    check("arst_data",    bus_data,     32'd0);
    #1 Rst_n = 1'b1;
    req = 4'b0110;
    step();
    check_owner("arst_o1", 1, words[1]);

    // Owner 3 drops request: gap without timeout, rr_ptr wraps to 0.
    do_reset();
    req = 4'b0100;
    step();
    check_owner("wrap_o2", 2, words[2]);
    req = 4'b1000;
    step();
    check_gap("wrap_gap1", 1'b0);
    step();
    check_owner("wrap_o3", 3, words[3]);
    req = 4'b0000;
    step();
    check_gap("wrap_gap2", 1'b0);
    req = 4'b1010;
    step();
    check_owner("wrap_o1", 1, words[1]);

    // Hold limit with MAX_HOLD = 4.
    do_reset();
    req = 4'b0001;
`ifdef ARB_HOLD_LIMIT_EN
    for (int c = 1; c <= 4; c++) begin
      step();
      check_owner("hold_own", 0, words[0]);
      check("hold_own_to", 32'(timeout), 32'd0);
    end
    step();
    check_gap("hold_gap", 1'b1);
    step();
    check_owner("hold_regrant", 0, words[0]);
    check("hold_regrant_to", 32'(timeout), 32'd0);
    // last in the MAX_HOLD cycle: normal release.
    step();
    step();
    step();
    last = 1'b1;
    step();
    last = 1'b0;
    check_gap("hold_last_gap", 1'b0);
`else
    for (int c = 1; c <= 7; c++) begin
      step();
      check_owner("nohold_own", 0, words[0]);
      check("nohold_to", 32'(timeout), 32'd0);
    end
    last = 1'b1;
    step();
    last = 1'b0;
    check_gap("nohold_gap", 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_4to1.md
BUS_ARBITER_4TO1 -- requirements
Module: bus_arbiter_4to1

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive OWN cycles per grant when the hold limit is compiled in; legal range 2..255.
REQ-002 Port: Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  request per requester; bit i high = requester i wants the shared bus.
REQ-005 Port: last  input  1  current owner's final cycle; sampled only in OWN.
REQ-006 Port: inA, inB, inC, inD  input  32 each  requester data words 0..3.
REQ-007 Port: gnt  output  4  registered one-hot grant; all-zero when no owner.
REQ-008 Port: sel  output  2  registered owner index; drives the 4:1 select.
REQ-009 Port: busy  output  1  registered; high exactly when in OWN.
REQ-010 Port: bus_data  output  32  selected data word.
REQ-011 Port: timeout  output  1  registered one-cycle pulse on forced release.

Function
REQ-012 FSM states IDLE, OWN, GAP; encoding free.
REQ-013 Arbitration (IDLE or GAP, req != 0): winner = first set req bit scanning rr_ptr, rr_ptr+1, ... mod 4; next cycle state OWN, gnt one-hot at winner, sel = winner, busy = 1.
REQ-014 Latency: req sampled high at edge N -> gnt high after edge N; no combinational path from req to gnt.
REQ-015 IDLE or GAP with req == 0: next state IDLE, gnt = 0, busy = 0.
REQ-016 OWN: gnt and sel held; non-owner req bits ignored.
REQ-017 OWN exit to GAP when any of: last = 1; owner's req bit = 0; hold limit reached (REQ-026).
REQ-018 GAP: one cycle, gnt = 0, busy = 0; guarantees >=1 dead cycle between owners; arbitration per REQ-013 during GAP.
REQ-019 On every OWN->GAP transition rr_ptr <= (owner index + 1) mod 4.
REQ-020 sel holds last owner index outside OWN; never changes except on a grant.
REQ-021 bus_data = inA/inB/inC/inD per sel while busy = 1, else 32'h0000_0000; combinational from sel, busy, inputs.
REQ-022 last outside OWN: no effect.
REQ-023 last and owner req drop in the same cycle: single normal release, timeout = 0.

Reset
REQ-024 Rst_n low asynchronously forces: state IDLE, gnt = 4'b0000, sel = 2'b00, busy = 0, timeout = 0, rr_ptr = 0, hold counter = 0; bus_data therefore 0.
REQ-025 Reset asserted mid-OWN aborts the grant immediately; first arbitration after release of Rst_n uses rr_ptr = 0.

Configuration
REQ-026 Macro ARB_HOLD_LIMIT_EN defined: hold counter = 1 on first OWN cycle, +1 each further OWN cycle; OWN cycle with counter == MAX_HOLD and last = 0 and owner req = 1 forces OWN->GAP, timeout = 1 during that GAP cycle only; counter cleared on leaving OWN.
REQ-027 ARB_HOLD_LIMIT_EN defined, last = 1 in the MAX_HOLD cycle: normal release, timeout = 0.
REQ-028 ARB_HOLD_LIMIT_EN undefined: no counter, MAX_HOLD unused, timeout tied 0, owner holds until last or req drop.

Verification
REQ-029 Reset, req = 4'b0101 held -> gnt = 0001, sel = 0 one cycle later; last pulse -> GAP (gnt = 0) -> gnt = 0100, sel = 2.
REQ-030 req = 4'b1111 continuously, owners assert last on 3rd OWN cycle -> grant order 0,1,2,3,0, one GAP cycle between each.
REQ-031 Owner 1 granted, inB = 32'hDEAD_BEEF -> bus_data = 32'hDEAD_BEEF while busy; GAP -> bus_data = 0.
REQ-032 ARB_HOLD_LIMIT_EN, MAX_HOLD = 4, req = 4'b0001, last = 0 -> busy high exactly 4 cycles, timeout pulse 1 cycle in GAP, regrant to 0 next cycle.
REQ-033 Rst_n pulsed low mid-OWN with owner 2 -> gnt/busy/sel/timeout = 0 without a clock edge; after release with req = 4'b0110 -> owner 1 granted.
REQ-034 Owner 3 drops req with last = 0 -> GAP next cycle, timeout = 0, rr_ptr = 0.
